// File: rtl/qe_mac_pkg.sv
// Shared types and defaults for the MAC arbiter slice.
// State encoding, default widths and job mode codes.
package qe_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int   DW_DEF  = 8;
  localparam int   RW_DEF  = 16;
  localparam logic MODE_QE = 1'b0;
  localparam logic MODE_PS = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// Ports: i_req[1:0], i_last_served in; o_any_req, o_winner out.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_served,
  output logic       o_any_req,
  output logic       o_winner
);

  assign o_any_req = |i_req;

  // On a tie the side that was not served last wins.
  always_comb begin
    o_winner = 1'b0;
    unique case (i_req)
      2'b11:   o_winner = ~i_last_served;
      2'b10:   o_winner = 1'b1;
      default: o_winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/qe_mac_arbiter.sv
// Shares one MAC datapath between two requesters, with a watchdog.
// Ports: clk, reset(n); rN_* client side; dp_* datapath side.
module qe_mac_arbiter
  import qe_mac_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_mode,
  input  logic [DW-1:0] r0_a,
  input  logic [DW-1:0] r0_b,
  input  logic [DW-1:0] r0_c,
  input  logic [DW-1:0] r0_x,
  input  logic          r0_valid,
  input  logic          r0_last,
  output logic          r0_gnt,
  output logic          r0_done,
  input  logic          r1_req,
  input  logic          r1_mode,
  input  logic [DW-1:0] r1_a,
  input  logic [DW-1:0] r1_b,
  input  logic [DW-1:0] r1_c,
  input  logic [DW-1:0] r1_x,
  input  logic          r1_valid,
  input  logic          r1_last,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic [RW-1:0] result,
  output logic          err,
  output logic          dp_mode,
  output logic [DW-1:0] dp_a,
  output logic [DW-1:0] dp_b,
  output logic [DW-1:0] dp_c,
  output logic [DW-1:0] dp_x,
  output logic          dp_valid_in,
  output logic          dp_last_input,
  input  logic          dp_valid_out,
  input  logic [RW-1:0] dp_result
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_owner;
  logic          r_last_served;
  logic          r_mode;
  logic          r_err;
  logic [RW-1:0] r_result;
  logic [7:0]    r_cnt;

  logic          w_any;
  logic          w_winner;
  logic          w_grant;
  logic          w_done;
  logic          w_valid;
  logic          w_last;
  logic          w_beat_end;
  logic          w_to;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_c;
  logic [DW-1:0] w_x;

  rr_arb2 u_arb (
    .i_req         ({r1_req, r0_req}),
    .i_last_served (r_last_served),
    .o_any_req     (w_any),
    .o_winner      (w_winner)
  );

  assign w_valid = r_owner ? r1_valid : r0_valid;
  assign w_last  = r_owner ? r1_last  : r0_last;
  assign w_a     = r_owner ? r1_a     : r0_a;
  assign w_b     = r_owner ? r1_b     : r0_b;
  assign w_c     = r_owner ? r1_c     : r0_c;
  assign w_x     = r_owner ? r1_x     : r0_x;

  assign w_grant    = (r_state == GRANT);
  assign w_done     = (r_state == DONE);
  assign w_beat_end = w_valid & w_last;
  assign w_to       = (r_cnt == TO_LAST);

  assign r0_gnt  = w_grant & ~r_owner;
  assign r1_gnt  = w_grant &  r_owner;
  assign r0_done = w_done  & ~r_owner;
  assign r1_done = w_done  &  r_owner;

  assign dp_a          = w_grant ? w_a : '0;
  assign dp_b          = w_grant ? w_b : '0;
  assign dp_c          = w_grant ? w_c : '0;
  assign dp_x          = w_grant ? w_x : '0;
  assign dp_valid_in   = w_grant & w_valid;
  assign dp_last_input = w_grant & w_beat_end;
  assign dp_mode       = r_mode;
  assign result        = r_result;
  assign err           = r_err;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = GRANT;
      GRANT:   if (w_beat_end) w_next = WAIT;
      WAIT:    if (dp_valid_out | w_to) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_last_served <= 1'b1;
      r_mode        <= 1'b0;
      r_err         <= 1'b0;
      r_result      <= '0;
      r_cnt         <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_winner;
            r_mode  <= w_winner ? r1_mode : r0_mode;
          end
        end
        GRANT: begin
          if (w_beat_end) r_cnt <= '0;
        end
        WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // A response in the final watchdog cycle still counts.
          if (dp_valid_out) begin
            r_result <= dp_result;
            r_err    <= 1'b0;
          end else if (w_to) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        DONE:    r_last_served <= r_owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qe_mac_arbiter.sv
// Self-checking bench for qe_mac_arbiter.
// Vector table, hand sequences and random jobs vs a job-level model.
module tb_qe_mac_arbiter;

  localparam int DW = 8;
  localparam int RW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req[2];
  logic          mode[2];
  logic          valid[2];
  logic          last[2];
  logic [DW-1:0] a[2];
  logic [DW-1:0] b[2];
  logic [DW-1:0] c[2];
  logic [DW-1:0] x[2];

  logic          r0_gnt, r1_gnt, r0_done, r1_done;
  logic [RW-1:0] result;
  logic          err, dp_mode;
  logic [DW-1:0] dp_a, dp_b, dp_c, dp_x;
  logic          dp_valid_in, dp_last_input;
  logic          dp_valid_out;
  logic [RW-1:0] dp_result;

  qe_mac_arbiter #(
    .DW(DW), .RW(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .r0_req(req[0]), .r0_mode(mode[0]),
    .r0_a(a[0]), .r0_b(b[0]), .r0_c(c[0]), .r0_x(x[0]),
    .r0_valid(valid[0]), .r0_last(last[0]),
    .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r1_req(req[1]), .r1_mode(mode[1]),
    .r1_a(a[1]), .r1_b(b[1]), .r1_c(c[1]), .r1_x(x[1]),
    .r1_valid(valid[1]), .r1_last(last[1]),
    .r1_gnt(r1_gnt), .r1_done(r1_done),
    .result(result), .err(err),
    .dp_mode(dp_mode),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_x(dp_x),
    .dp_valid_in(dp_valid_in),
    .dp_last_input(dp_last_input),
    .dp_valid_out(dp_valid_out),
    .dp_result(dp_result)
  );

  typedef struct {
    logic [1:0]  rq;
    int          w;
    logic [7:0]  va, vb, vc, vx;
    int          lat;
    logic [15:0] resp;
    logic [15:0] er;
    logic        ee;
  } vec_t;

  vec_t        tbl[8];
  int          n_pass = 0;
  int          n_total = 0;
  logic        ls_m;
  logic [7:0]  ba[8], bb[8], bc[8], bx[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Mathematical value of a job from the operands the client issued.
  function automatic logic [15:0] ref_val(input logic m, input int nb);
    int s;
    s = 0;
    if (!m) begin
      s = int'(ba[0]) * int'(bx[0]) * int'(bx[0])
        + int'(bb[0]) * int'(bx[0]) + int'(bc[0]);
    end else begin
      for (int i = 0; i < nb; i++)
        s += int'(ba[i]) * int'(bx[i]);
    end
    return 16'(s);
  endfunction

  // Caller raises req at an IDLE negedge; the bench also plays the
  // datapath, answering lat cycles after the last beat (lat > TO means
  // it answers too late or never).
  task automatic run_job(input int w, input logic m,
                         input int nb, input int gap,
                         input int lat, input logic use_calc,
                         input logic [15:0] resp,
                         input logic [15:0] er, input logic ee,
                         input string nm);
    int          waited;
    int          endk;
    int          acc;
    logic [15:0] rsp;
    mode[w]   = m;
    mode[1-w] = ~m;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(r0_gnt | r1_gnt) && waited < 8);
    chk({nm, " gnt latency"}, waited, 1);
    chk({nm, " gnt"}, {r1_gnt, r0_gnt}, (w == 1) ? 2'b10 : 2'b01);
    if (!(r0_gnt | r1_gnt)) begin
      req[w] = 1'b0;
      return;
    end
    req[w] = 1'b0;
    acc = 0;
    for (int i = 0; i < nb; i++) begin
      if (i == gap) begin
        valid[w] = 1'b0; last[w] = 1'b1;
        valid[1-w] = 1'b1; last[1-w] = 1'b1;
        #1;
        chk({nm, " gap strobes"}, {dp_valid_in, dp_last_input}, 0);
        chk({nm, " gap gnt"}, {r1_gnt, r0_gnt},
            (w == 1) ? 2'b10 : 2'b01);
        @(negedge clk);
      end
      a[w] = ba[i]; b[w] = bb[i]; c[w] = bc[i]; x[w] = bx[i];
      valid[w] = 1'b1;
      last[w]  = (i == nb - 1);
      a[1-w] = ~ba[i]; b[1-w] = ~bb[i];
      c[1-w] = ~bc[i]; x[1-w] = ~bx[i];
      valid[1-w] = 1'($urandom_range(1, 0));
      last[1-w]  = 1'b1;
      #1;
      chk({nm, " beat ctl"},
          {dp_valid_in, dp_last_input, dp_mode},
          {1'b1, (i == nb - 1), m});
      chk({nm, " beat ops"}, {dp_a, dp_b, dp_c, dp_x},
          {ba[i], bb[i], bc[i], bx[i]});
      if (m) acc += int'(dp_a) * int'(dp_x);
      else acc = int'(dp_a) * int'(dp_x) * int'(dp_x)
               + int'(dp_b) * int'(dp_x) + int'(dp_c);
      if (i != nb - 1) @(negedge clk);
    end
    rsp  = use_calc ? 16'(acc) : resp;
    endk = ((lat < TO) ? lat : TO) + 1;
    for (int k = 1; k <= endk; k++) begin
      @(negedge clk);
      valid[0] = 1'b0; valid[1] = 1'b0;
      last[0]  = 1'b0; last[1]  = 1'b0;
      dp_valid_out = (k == lat);
      dp_result    = (k == lat) ? rsp : 16'hDEAD;
      #1;
      if (k < endk) begin
        chk({nm, " wait quiet"},
            {dp_valid_in, dp_last_input, dp_a, dp_x,
             r0_gnt, r1_gnt, r0_done, r1_done}, 0);
        chk({nm, " wait mode"}, dp_mode, m);
      end else begin
        chk({nm, " done"}, {r1_done, r0_done},
            (w == 1) ? 2'b10 : 2'b01);
        chk({nm, " result"}, result, er);
        chk({nm, " err"}, err, ee);
      end
    end
    @(negedge clk);
    dp_valid_out = 1'b0;
    #1;
    chk({nm, " idle"}, {r0_done, r1_done, r0_gnt, r1_gnt}, 0);
    chk({nm, " hold"}, {err, result}, {ee, er});
    ls_m = (w == 1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " ctl"},
        {r0_gnt, r1_gnt, r0_done, r1_done, err, dp_mode,
         dp_valid_in, dp_last_input}, 0);
    chk({nm, " result"}, result, 0);
    chk({nm, " ops"}, {dp_a, dp_b, dp_c, dp_x}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          w, nb, gap, lat;
    logic        m, ee;
    logic [15:0] er;

    tbl[0] = '{2'b01, 0, 8'd2, 8'd3, 8'd4, 8'd5,
               2, 16'h0041, 16'h0041, 1'b0};
    tbl[1] = '{2'b10, 1, 8'd7, 8'd0, 8'd1, 8'd3,
               1, 16'hBEEF, 16'hBEEF, 1'b0};
    tbl[2] = '{2'b11, 0, 8'd1, 8'd1, 8'd1, 8'd1,
               TO, 16'h1234, 16'h1234, 1'b0};
    tbl[3] = '{2'b10, 1, 8'd9, 8'd8, 8'd7, 8'd6,
               TO + 1, 16'h5555, 16'h0000, 1'b1};
    tbl[4] = '{2'b01, 0, 8'd4, 8'd4, 8'd4, 8'd4,
               40, 16'h7777, 16'h0000, 1'b1};
    tbl[5] = '{2'b01, 0, 8'd5, 8'd6, 8'd7, 8'd8,
               3, 16'h00A5, 16'h00A5, 1'b0};
    tbl[6] = '{2'b11, 1, 8'd1, 8'd2, 8'd3, 8'd4,
               5, 16'h0F0F, 16'h0F0F, 1'b0};
    tbl[7] = '{2'b01, 0, 8'd255, 8'd0, 8'd0, 8'd255,
               1, 16'h8001, 16'h8001, 1'b0};

    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; mode[s] = 1'b0;
      valid[s] = 1'b0; last[s] = 1'b0;
      a[s] = '0; b[s] = '0; c[s] = '0; x[s] = '0;
    end
    dp_valid_out = 1'b0;
    dp_result    = '0;
    reset = 1'b0;
    ls_m  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      ba[0] = tbl[i].va; bb[0] = tbl[i].vb;
      bc[0] = tbl[i].vc; bx[0] = tbl[i].vx;
      if (tbl[i].rq[0]) req[0] = 1'b1;
      if (tbl[i].rq[1]) req[1] = 1'b1;
      run_job(tbl[i].w, 1'b0, 1, 9, tbl[i].lat, 1'b0,
              tbl[i].resp, tbl[i].er, tbl[i].ee,
              $sformatf("vec%0d", i));
    end

    ba[0] = 8'd1; bx[0] = 8'd2;
    ba[1] = 8'd3; bx[1] = 8'd4;
    ba[2] = 8'd5; bx[2] = 8'd6;
    for (int i = 0; i < 3; i++) begin
      bb[i] = '0; bc[i] = '0;
    end
    req[1] = 1'b1;
    run_job(1, 1'b1, 3, 1, 2, 1'b1, 16'h0, 16'h002C, 1'b0,
            "stream");

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ls_m  = 1'b1;
    req[0] = 1'b1;
    req[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      w = j % 2;
      ba[0] = 8'($urandom); bb[0] = 8'($urandom);
      bc[0] = 8'($urandom); bx[0] = 8'($urandom);
      er = ref_val(1'b0, 1);
      run_job(w, 1'b0, 1, 9, 2, 1'b1, 16'h0, er, 1'b0,
              $sformatf("tie%0d", j));
      if (j < 3) req[w] = 1'b1;
    end

    mode[0] = 1'b1;
    a[0] = 8'h11; b[0] = 8'h22; c[0] = 8'h33; x[0] = 8'h44;
    @(negedge clk);
    chk("rst job gnt", {r1_gnt, r0_gnt}, 2'b01);
    req[0] = 1'b0; valid[0] = 1'b1; last[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0; last[0] = 1'b0;
    @(negedge clk);
    chk("rst job mode", dp_mode, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_outs("async rst");
    @(negedge clk);
    reset = 1'b1;
    dp_valid_out = 1'b1;
    dp_result    = 16'hCAFE;
    @(negedge clk);
    dp_valid_out = 1'b0;
    #1;
    chk("stale ctl", {r0_done, r1_done, r0_gnt, r1_gnt, err}, 0);
    chk("stale result", result, 0);
    ls_m = 1'b1;
    req[1] = 1'b1;
    ba[0] = 8'd3; bb[0] = 8'd1; bc[0] = 8'd2; bx[0] = 8'd4;
    run_job(1, 1'b0, 1, 9, 4, 1'b1, 16'h0, 16'd54, 1'b0,
            "post rst r1");

    for (int it = 0; it < 30; it++) begin
      for (int s = 0; s < 2; s++)
        if (!req[s] && $urandom_range(1, 0) == 1) req[s] = 1'b1;
      if (!req[0] && !req[1]) req[$urandom_range(1, 0)] = 1'b1;
      w = (req[0] && req[1]) ? int'(!ls_m) : int'(req[1]);
      m   = 1'($urandom_range(1, 0));
      nb  = m ? int'($urandom_range(4, 1)) : 1;
      gap = int'($urandom_range(nb + 1, 0));
      for (int i = 0; i < nb; i++) begin
        ba[i] = 8'($urandom); bb[i] = 8'($urandom);
        bc[i] = 8'($urandom); bx[i] = 8'($urandom);
      end
      lat = int'($urandom_range(TO + 3, 1));
      ee  = (lat > TO);
      er  = ee ? 16'h0 : ref_val(m, nb);
      run_job(w, m, nb, gap, lat, 1'b1, 16'h0, er, ee,
              $sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
